// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM timer: configuration address
// map and the encodings of the counting mode and counting direction.
// The PWM_PRELOAD_EN build macro selects shadow/active double-buffering.
package pwm_pkg;

    // Configuration address map: period first, then one compare per channel.
    localparam int ADDR_PERIOD   = 0;
    localparam int ADDR_CCR_BASE = 1;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM compare channel: compare register(s), duty rule, polarity and the
// registered output. With PWM_PRELOAD_EN a shadow compare feeds the active
// compare at counter boundaries; without it writes land in the active
// compare directly.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             load_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic [WIDTH-1:0] period_i,
    input  logic             pol_i,
    output logic             pwm_o
);

    logic [WIDTH-1:0] ccr_act_q, ccr_act_d;
    logic             raw;
    logic             pwm_q, pwm_d;

`ifdef PWM_PRELOAD_EN
    logic [WIDTH-1:0] ccr_shd_q, ccr_shd_d;

    // Shadow takes every write; active loads at a boundary, a same-cycle write wins.
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        ccr_shd_d = ccr_shd_q;
        ccr_act_d = ccr_act_q;
        if (wr_i) begin
            ccr_shd_d = wdata_i;
        end
        if (load_i) begin
            ccr_act_d = wr_i ? wdata_i : ccr_shd_q;
        end
    end

    // Shadow compare register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ccr_shd_q <= '0;
        end else begin
            ccr_shd_q <= ccr_shd_d;
        end
    end
`else
    logic unused_load;
    assign unused_load = load_i;

    // Writes go straight to the active compare.
    always_comb begin
        ccr_act_d = wr_i ? wdata_i : ccr_act_q;
    end
`endif

    // Duty rule: zero is off, compare at or above period is full on, else cnt < compare.
    always_comb begin
        raw = 1'b0;
        if (enable_i && (ccr_act_q != '0)) begin
            raw = (ccr_act_q >= period_i) || (cnt_i < ccr_act_q);
        end
        pwm_d = raw ^ pol_i;
    end

    // Active compare and output register.
    // NOTE: configuration registers are reset too, so the output is defined from the first edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ccr_act_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values.
            ccr_act_q <= ccr_act_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_timer.sv
// Multi-channel PWM timer: shared edge- or center-aligned counter, period
// register(s), configuration write decode and CHANNELS compare channels.
// Build macro PWM_PRELOAD_EN enables double-buffered period and compares.
module pwm_timer
    import pwm_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 4,
    localparam int AW       = $clog2(CHANNELS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                center_mode,
    input  logic [CHANNELS-1:0] pol,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [WIDTH-1:0]    cfg_wdata,
    output logic [CHANNELS-1:0] pwm_out,
    output logic [WIDTH-1:0]    cnt,
    output logic                dir,
    output logic                update_evt
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    mode_e            mode_q, mode_d;
    dir_e             dir_q, dir_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] per_act_q, per_act_d;
    logic             per_wr;
    logic             upd;
    logic             load;

    assign per_wr = cfg_we && (cfg_addr == AW'(ADDR_PERIOD));

    // Next counter value and direction for the current mode and active period.
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (!enable || (per_act_q == '0)) begin
            cnt_d = '0;
            dir_d = DIR_UP;
        end else if (mode_q == MODE_EDGE) begin
            dir_d = DIR_UP;
            cnt_d = (cnt_q >= per_act_q - CNT_ONE) ? '0 : cnt_q + CNT_ONE;
        end else if (dir_q == DIR_UP) begin
            if (cnt_q >= per_act_q) begin
                // Overshoot after a direct period shrink: restart at the valley.
                cnt_d = '0;
                dir_d = DIR_UP;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
                dir_d = (cnt_q + CNT_ONE == per_act_q) ? DIR_DOWN : DIR_UP;
            end
        end else begin
            if (cnt_q <= CNT_ONE) begin
                cnt_d = '0;
                dir_d = DIR_UP;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
                dir_d = DIR_DOWN;
            end
        end
    end

    // Boundary event: enabled cycle whose next count is zero.
    assign upd        = enable && (cnt_d == '0) && !rst;
    assign update_evt = upd;
    // Active registers also track their source every cycle while stopped.
    assign load       = upd || !enable;

    // Mode is only sampled while the timer is stopped.
    always_comb begin
        mode_d = mode_q;
        if (!enable) begin
            mode_d = center_mode ? MODE_CENTER : MODE_EDGE;
        end
    end

`ifdef PWM_PRELOAD_EN
    logic [WIDTH-1:0] per_shd_q, per_shd_d;

    // Shadow period takes writes; active period loads at boundaries, write wins.
    always_comb begin
        per_shd_d = per_wr ? cfg_wdata : per_shd_q;
        per_act_d = per_act_q;
        if (load) begin
            per_act_d = per_wr ? cfg_wdata : per_shd_q;
        end
    end

    // Shadow period register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_shd_q <= '0;
        end else begin
            per_shd_q <= per_shd_d;
        end
    end
`else
    // Period writes go straight to the active register.
    always_comb begin
        per_act_d = per_wr ? cfg_wdata : per_act_q;
    end
`endif

    // Counter, direction, mode and active period registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            dir_q     <= DIR_UP;
            mode_q    <= MODE_EDGE;
            per_act_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            mode_q    <= mode_d;
            per_act_q <= per_act_d;
        end
    end

    assign cnt = cnt_q;
    assign dir = dir_q;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic ch_wr;
        assign ch_wr = cfg_we && (cfg_addr == AW'(ADDR_CCR_BASE + k));

        pwm_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .enable_i (enable),
            .load_i   (load),
            .wr_i     (ch_wr),
            .wdata_i  (cfg_wdata),
            .cnt_i    (cnt_q),
            .period_i (per_act_q),
            .pol_i    (pol[k]),
            .pwm_o    (pwm_out[k])
        );
    end

endmodule

// File: tb/tb_pwm_timer.sv
// Directed testbench for pwm_timer (WIDTH=16, CHANNELS=4). Expectations for
// the preload scenario follow the PWM_PRELOAD_EN build macro.
module tb_pwm_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        center_mode;
    logic [3:0]  pol;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [3:0]  pwm_out;
    logic [15:0] cnt;
    logic        dir;
    logic        update_evt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pwm_timer #(
        .WIDTH    (16),
        .CHANNELS (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .center_mode (center_mode),
        .pol         (pol),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .pwm_out     (pwm_out),
        .cnt         (cnt),
        .dir         (dir),
        .update_evt  (update_evt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic [15:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
        cfg_we    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_pwm;
        logic       hi;
        int         prev;
        int         s;
        int         ps;
        int         pc;
        int         highs;

        rst         = 1'b0;
        enable      = 1'b0;
        center_mode = 1'b0;
        pol         = 4'b1010;
        cfg_we      = 1'b0;
        cfg_addr    = '0;
        cfg_wdata   = '0;

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst_async_cnt", 32'(cnt), 32'd0);
        check("rst_async_pwm", 32'(pwm_out), 32'd0);
        tick();
        tick();
        check("rst_hold_pwm", 32'(pwm_out), 32'd0);
        check("rst_hold_upd", 32'(update_evt), 32'd0);
        check("rst_hold_dir", 32'(dir), 32'd0);
        rst = 1'b0;
        tick();
        check("rel_pwm_pol", 32'(pwm_out), 32'h0000000a);
        check("rel_cnt", 32'(cnt), 32'd0);

        // Edge mode, P=10: C0=3, C1=0, C2=10, C3=15; out-of-range address ignored.
        pol = 4'b0000;
        cfg_write(3'd0, 16'd10);
        cfg_write(3'd1, 16'd3);
        cfg_write(3'd2, 16'd0);
        cfg_write(3'd3, 16'd10);
        cfg_write(3'd4, 16'd15);
        cfg_write(3'd5, 16'd1);
        enable = 1'b1;
        #1;
        check("edge_start_upd", 32'(update_evt), 32'd0);
        for (int k = 1; k <= 30; k++) begin
            tick();
            prev    = (k - 1) % 10;
            exp_pwm = {1'b1, 1'b1, 1'b0, (prev < 3)};
            if (k > 20) exp_pwm = exp_pwm ^ 4'hf;
            check($sformatf("edge_cnt k=%0d", k), 32'(cnt), 32'(k % 10));
            check($sformatf("edge_upd k=%0d", k), 32'(update_evt), 32'((k % 10) == 9));
            check($sformatf("edge_dir k=%0d", k), 32'(dir), 32'd0);
            check($sformatf("edge_pwm k=%0d", k), 32'(pwm_out), 32'(exp_pwm));
            if (k == 20) pol = 4'hf;
        end
        pol = 4'b0000;
        for (int k = 31; k <= 35; k++) begin
            tick();
            prev = (k - 1) % 10;
            check($sformatf("edge2_cnt k=%0d", k), 32'(cnt), 32'(k % 10));
            check($sformatf("edge2_pwm k=%0d", k), 32'(pwm_out), 32'({1'b1, 1'b1, 1'b0, (prev < 3)}));
        end

        // Drop enable at cnt=5 while requesting center mode.
        enable      = 1'b0;
        center_mode = 1'b1;
        pol         = 4'b0110;
        #1;
        check("drop_upd_now", 32'(update_evt), 32'd0);
        tick();
        check("drop_cnt", 32'(cnt), 32'd0);
        check("drop_pwm_pol", 32'(pwm_out), 32'h00000006);
        check("drop_dir", 32'(dir), 32'd0);
        check("drop_upd", 32'(update_evt), 32'd0);

        // Center mode, P=8, C0=2; center_mode input changed after enable is ignored.
        pol = 4'b0000;
        cfg_write(3'd0, 16'd8);
        cfg_write(3'd1, 16'd2);
        enable      = 1'b1;
        center_mode = 1'b0;
        #1;
        check("ctr_start_upd", 32'(update_evt), 32'd0);
        highs = 0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            s  = k % 16;
            ps = (k - 1) % 16;
            pc = (ps <= 8) ? ps : 16 - ps;
            check($sformatf("ctr_cnt k=%0d", k), 32'(cnt), 32'((s <= 8) ? s : 16 - s));
            check($sformatf("ctr_dir k=%0d", k), 32'(dir), 32'(s >= 8));
            check($sformatf("ctr_upd k=%0d", k), 32'(update_evt), 32'(s == 15));
            check($sformatf("ctr_pwm k=%0d", k), 32'(pwm_out), 32'({1'b1, 1'b1, 1'b0, (pc < 2)}));
            if (pwm_out[0]) highs++;
        end
        check("ctr_high_count", 32'(highs), 32'd6);

        // Preload: C0=5, write 2 at cnt=2, write 7 in an update_evt cycle.
        enable      = 1'b0;
        center_mode = 1'b0;
        tick();
        cfg_write(3'd0, 16'd10);
        cfg_write(3'd1, 16'd5);
        enable = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
`ifdef PWM_PRELOAD_EN
            hi = (k <= 5) || (k == 11) || (k == 12) || (k >= 21 && k <= 27);
`else
            hi = (k <= 3) || (k == 11) || (k == 12) || (k >= 21 && k <= 27);
`endif
            check($sformatf("pre_cnt k=%0d", k), 32'(cnt), 32'(k % 10));
            check($sformatf("pre_upd k=%0d", k), 32'(update_evt), 32'((k % 10) == 9));
            check($sformatf("pre_pwm k=%0d", k), 32'(pwm_out), 32'({1'b1, 1'b1, 1'b0, hi}));
            if (k == 2) begin
                cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wdata = 16'd2;
            end else if (k == 19) begin
                cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wdata = 16'd7;
            end else begin
                cfg_we = 1'b0;
            end
        end

        // Asynchronous reset mid-period at cnt=6, no clock edge.
        for (int k = 31; k <= 36; k++) tick();
        check("mid_cnt", 32'(cnt), 32'd6);
        check("mid_pwm", 32'(pwm_out), 32'h0000000d);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_cnt", 32'(cnt), 32'd0);
        check("rst_mid_pwm", 32'(pwm_out), 32'd0);
        check("rst_mid_dir", 32'(dir), 32'd0);
        check("rst_mid_upd", 32'(update_evt), 32'd0);
        pol = 4'b0011;
        rst = 1'b0;
        tick();
        check("rel2_cnt", 32'(cnt), 32'd0);
        check("rel2_pwm_pol", 32'(pwm_out), 32'h00000003);
        check("rel2_upd_p0", 32'(update_evt), 32'd1);
        pol = 4'b0000;
        cfg_write(3'd1, 16'd2);
        check("p0_cnt_hold", 32'(cnt), 32'd0);
        check("p0_upd", 32'(update_evt), 32'd1);
        check("p0_pwm", 32'(pwm_out), 32'd0);
        cfg_write(3'd0, 16'd4);
        check("p4_cnt", 32'(cnt), 32'd0);
        check("p4_pwm_full", 32'(pwm_out), 32'd1);
        check("p4_upd", 32'(update_evt), 32'd0);
        for (int j = 1; j <= 8; j++) begin
            tick();
            check($sformatf("rst_run_cnt j=%0d", j), 32'(cnt), 32'(j % 4));
            check($sformatf("rst_run_upd j=%0d", j), 32'(update_evt), 32'((j % 4) == 3));
            check($sformatf("rst_run_pwm j=%0d", j), 32'(pwm_out), 32'(((j - 1) % 4) < 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
